// File: rtl/ascon128a_input_loader_pkg.sv
// ascon_pkg: shared constants for the Ascon-128a front end.
//   ASCON_BLK_W      width of every field handed to the core
//   FLD_SK..FLD_P    field index in stream order
//   ST_LOAD/FIRE/WAIT  2-bit state codes, shared with the output serializer
package ascon_pkg;

    localparam int ASCON_BLK_W = 128;

    localparam int FLD_SK = 0;
    localparam int FLD_N  = 1;
    localparam int FLD_A  = 2;
    localparam int FLD_P  = 3;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_FIRE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef enum logic [1:0] {
        LOAD = ST_LOAD,
        FIRE = ST_FIRE,
        WAIT = ST_WAIT
    } state_t;

endpackage

// File: rtl/ascon128a_input_loader_if.sv
// ascon128a_input_loader_if: narrow word stream with valid/ready handshake.
//   s_data   stream word (WORD_W bits)
//   s_valid  s_data is valid
//   s_last   final word of a frame, qualified by s_valid
//   s_ready  receiver accepts a word this cycle
// Modports: master drives the stream, slave is the loader.
interface ascon128a_input_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/ascon128a_input_loader_field_reg.sv
// ascon_field_reg: 128-bit register written one WORD_W slot at a time.
//   CLK, RST  clock and asynchronous active-high reset
//   we        write enable for this field
//   slot      slot index; slot 0 is the most significant word
//   word      data written into the selected slot
//   q         current register contents
module ascon_field_reg
    import ascon_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      we,
    input  logic [$clog2(ASCON_BLK_W/WORD_W)-1:0]     slot,
    input  logic [WORD_W-1:0]                         word,
    output logic [ASCON_BLK_W-1:0]                    q
);

    // Slot 0 lands at the top so the field reads in hex text order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q <= '0;
        end else if (we) begin
            q[ASCON_BLK_W-1-int'(slot)*WORD_W -: WORD_W] <= word;
        end
    end

endmodule

// File: rtl/ascon128a_input_loader.sv
// ascon128a_input_loader: assembles SK, N, A, P from a word stream, fires
// the Ascon-128a core once per well-formed frame and waits for it to finish.
//   CLK, RST    clock and asynchronous active-high reset
//   s           stream slave port (s_data/s_valid/s_last/s_ready)
//   key_reload  only with ASCON_KEY_REUSE_EN: force a full frame incl. SK
//   SK/N/A/P    128-bit fields to the core, stable from FIRE through WAIT
//   core_start  one-cycle start pulse
//   core_done   core finished; only looked at in WAIT
//   busy        high in FIRE and WAIT
//   frame_err   one-cycle pulse when a malformed frame is dropped
// Optional macro ASCON_KEY_REUSE_EN: after the first fired frame, frames
// may omit SK and start at the nonce.
module ascon128a_input_loader
    import ascon_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    ascon128a_input_loader_if.slave       s,
`ifdef ASCON_KEY_REUSE_EN
    input  logic                          key_reload,
`endif
    output logic [ASCON_BLK_W-1:0]        SK,
    output logic [ASCON_BLK_W-1:0]        N,
    output logic [ASCON_BLK_W-1:0]        A,
    output logic [ASCON_BLK_W-1:0]        P,
    output logic                          core_start,
    input  logic                          core_done,
    output logic                          busy,
    output logic                          frame_err
);

    localparam int WPF    = ASCON_BLK_W / WORD_W;
    localparam int SLOT_W = $clog2(WPF);
    localparam int CNT_W  = $clog2(4 * WPF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(4 * WPF - 1);
    localparam logic [CNT_W-1:0] CNT_NONCE = CNT_W'(WPF);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   wcnt;
    logic               ready_q;
    logic               accept;
    logic [1:0]         wfield;
    logic [SLOT_W-1:0]  wslot;
    logic [ASCON_BLK_W-1:0] fld [4];

    assign s.s_ready = ready_q;
    assign accept    = s.s_valid & ready_q;

`ifdef ASCON_KEY_REUSE_EN
    logic key_loaded;
    logic fresh;

    // A reload request before the first word of a frame rewinds to SK,
    // including a word accepted in that same cycle.
    assign wcnt = (key_reload && fresh) ? '0 : cnt;
`else
    assign wcnt = cnt;
`endif

    // Upper two counter bits select the field, the rest the slot.
    assign wfield = wcnt[CNT_W-1 -: 2];
    assign wslot  = wcnt[SLOT_W-1:0];

    for (genvar g = 0; g < 4; g++) begin : g_fld
        ascon_field_reg #(.WORD_W(WORD_W)) u_reg (
            .CLK  (CLK),
            .RST  (RST),
            .we   (accept && (wfield == 2'(g))),
            .slot (wslot),
            .word (s.s_data),
            .q    (fld[g])
        );
    end

    assign SK = fld[FLD_SK];
    assign N  = fld[FLD_N];
    assign A  = fld[FLD_A];
    assign P  = fld[FLD_P];

    // Frame FSM with word counter. All handshake and status outputs are
    // registered; s_ready comes up one cycle after reset release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= LOAD;
            cnt        <= '0;
            ready_q    <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
`ifdef ASCON_KEY_REUSE_EN
            key_loaded <= 1'b0;
            fresh      <= 1'b1;
`endif
        end else begin
            core_start <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                LOAD: begin
                    ready_q <= 1'b1;
`ifdef ASCON_KEY_REUSE_EN
                    if (key_reload && fresh) begin
                        cnt <= '0;
                    end
`endif
                    if (accept) begin
`ifdef ASCON_KEY_REUSE_EN
                        fresh <= 1'b0;
`endif
                        if (wcnt == CNT_LAST && s.s_last) begin
                            state      <= FIRE;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            ready_q    <= 1'b0;
                            cnt        <= '0;
                        end else if (wcnt == CNT_LAST || s.s_last) begin
                            // Malformed frame: drop it, keep the garbage bits.
                            frame_err <= 1'b1;
                            cnt       <= '0;
`ifdef ASCON_KEY_REUSE_EN
                            fresh     <= 1'b1;
`endif
                        end else begin
                            cnt <= wcnt + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    state <= WAIT;
`ifdef ASCON_KEY_REUSE_EN
                    key_loaded <= 1'b1;
`endif
                end
                WAIT: begin
                    if (core_done) begin
                        state   <= LOAD;
                        busy    <= 1'b0;
                        ready_q <= 1'b1;
`ifdef ASCON_KEY_REUSE_EN
                        fresh   <= 1'b1;
                        cnt     <= key_loaded ? CNT_NONCE : '0;
`else
                        cnt     <= '0;
`endif
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/ascon128a_input_loader.md
Name: ascon128a_input_loader

Overview:
Upstream feeder for the Ascon-128a encrypt core. It assembles SK, N, A and P from a narrow word stream that uses a valid/ready handshake. Once all four fields are loaded, it holds them stable, pulses core_start, and waits for core_done before it accepts the next frame. It replaces the bench-level file-driven stimulus with a synthesizable front end.

Parameters:
WORD_W, 32, stream word width in bits; must divide 128 (legal: 8, 16, 32, 64).
WPF, 128/WORD_W, words per 128-bit field (derived localparam, not overridable).

Ports:
CLK  in  1  single system clock, rising edge.
RST  in  1  reset, asynchronous and active-high.
s_data  in  WORD_W  stream word.
s_valid  in  1  s_data is valid.
s_last  in  1  marks the final word of a frame; qualified by s_valid.
s_ready  out  1  loader accepts a word this cycle.
SK  out  128  key to core.
N  out  128  nonce to core.
A  out  128  associated data to core.
P  out  128  plaintext to core.
core_start  out  1  one-cycle pulse; all fields are valid and stable.
core_done  in  1  core result is complete; level or pulse, sampled only in WAIT.
busy  out  1  high in FIRE and WAIT.
frame_err  out  1  one-cycle pulse when a malformed frame is discarded.

Behaviour:
- A word transfers when s_valid && s_ready on a rising edge of CLK.
- Field order is SK, N, A, P. Within a field, the first word goes into bits [127:128-WORD_W] (most significant first), matching the hex text order. The last word of a field fills [WORD_W-1:0].
- Word counter cnt is clog2(4*WPF) bits and increments per accepted word. The field is cnt/WPF; the slot is cnt%WPF.
- States and transitions:
  - LOAD: s_ready=1. When the word accepted at cnt=4*WPF-1 carries s_last=1, go to FIRE.
  - FIRE: 1 cycle, core_start=1, s_ready=0. Go to WAIT.
  - WAIT: s_ready=0. When core_done=1 is sampled, go to LOAD with cnt=0. core_done is ignored in LOAD and FIRE.
- Error rules (LOAD only):
  - A word accepted with s_last=1 while cnt != 4*WPF-1: frame_err pulses the next cycle and cnt becomes 0. Already-written field bits are left as garbage and are not cleared. The state stays LOAD.
  - The word at cnt=4*WPF-1 accepted with s_last=0: same response (frame_err, cnt becomes 0, no FIRE).
- SK/N/A/P change only on accepted words. They are stable from the FIRE cycle through the end of WAIT.
- Reset (asynchronous, any state, including mid-frame or in WAIT): state=LOAD, cnt=0, SK=N=A=P=0, core_start=0, busy=0, frame_err=0. s_ready is 0 while RST is high and becomes 1 on the first cycle after release. A partial frame is lost. An in-flight core_done is not waited for.
- Latency: core_start goes high on the cycle after the last word is accepted. The minimum frame is 4*WPF+2 cycles plus the core time.

Optional Feature:
ASCON_KEY_REUSE_EN:
- When defined, the input port key_reload (in, 1) and a key_loaded flag exist. key_loaded is reset to 0 and set at each FIRE.
- On entry to LOAD from WAIT, cnt starts at WPF (SK skipped) if key_loaded=1.
- key_reload=1 while in LOAD with no word yet accepted in the current frame forces cnt=0, and a full frame is expected.
- The s_last check uses the same final index 4*WPF-1.
- When the macro is undefined: no key_reload port, and every frame carries SK.

Decomposition:
- Package ascon_pkg holds:
  - ASCON_BLK_W=128 and the field index constants FLD_SK=0, FLD_N=1, FLD_A=2, FLD_P=3.
  - State encoding LOAD/FIRE/WAIT (2-bit localparams, shared with a future output serializer).
- One natural sub-module: ascon_field_reg. It is a 128-bit word-slot write register (inputs: we, slot, word); four instances are used.
- The FSM and counter stay in the top of the block.

Test Plan:
- WORD_W=32, one frame: SK=000102..0F, N=101112..1F, A=202122..2F, P=303132..3F, 16 words, last has s_last=1 → SK/N/A/P equal those values; core_start pulses exactly one cycle after word 16; busy=1; s_ready=0 until core_done.
- Back-to-back: core_done asserted 5 cycles after start → s_ready rises the next cycle; a second frame loads; no extra core_start pulse.
- s_last on word 9 → frame_err pulses once, no core_start; the following correct 16-word frame fires normally.
- Word 16 without s_last → frame_err, no core_start, state stays LOAD with cnt=0.
- RST pulsed mid-frame (after word 7) and in WAIT → all outputs 0, s_ready=0 during reset; a full frame afterwards works.
- ASCON_KEY_REUSE_EN: first frame 16 words, second frame 12 words → SK unchanged; N/A/P updated; core_start fires. With key_reload=1, the next frame needs 16 words.
